bf_bus_seq: RTL

- Parametrised successor to the top-level BF bus sequencer. Serialises one core memory/IO request onto the narrow external pad bus as a sequence of beats: opcode, then address beats MSB-first, then data beats.
- Adds what the previous generation lacks: configurable bus, address and data widths; multi-beat data; a valid/ready core handshake; a response strobe; an acknowledge timeout with a sticky error.
- Sits between the BF core and the chip pads.

---
 rtl/bf_bus_seq_if.sv | 32 +++
 rtl/bf_bus_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bf_bus_seq_if.sv
// Signal bundle between the BF core, the bf_bus_seq sequencer and the pad bus.
// The master modport is the core/pad side; the slave modport is the sequencer.
interface bf_bus_seq_if #(
   parameter int BUS_W  = 8,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
);
   logic              req_valid;
   logic [OP_W-1:0]   req_op;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic [BUS_W-1:0]  bus_out;
   logic [BUS_W-1:0]  bus_in;
   logic              bus_ack;
   logic [2:0]        bus_phase;
   logic              error;

   modport master (
      output req_valid, req_op, req_write, req_addr, req_wdata, bus_in, bus_ack,
      input  req_ready, rsp_valid, rsp_rdata, bus_out, bus_phase, error
   );

   modport slave (
      input  req_valid, req_op, req_write, req_addr, req_wdata, bus_in, bus_ack,
      output req_ready, rsp_valid, rsp_rdata, bus_out, bus_phase, error
   );
endinterface

// File: rtl/bf_bus_seq.sv
// Serialises one core request onto the narrow pad bus as opcode, address
// beats (MSB first) and data beats, with ack timeout and sticky error.
module bf_bus_seq #(
   parameter int BUS_W   = 8,
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 8,
   parameter int OP_W    = 3,
   parameter int TIMEOUT = 255
) (
   input logic         clock,
   input logic         reset,
   input logic         enable,
   bf_bus_seq_if.slave io
);
   localparam int NA   = (ADDR_W + BUS_W - 1) / BUS_W;
   localparam int ND   = (DATA_W + BUS_W - 1) / BUS_W;
   localparam int AE_W = NA * BUS_W;
   localparam int DE_W = ND * BUS_W;
   localparam int BMAX = (NA > ND) ? NA : ND;
   localparam int BC_W = (BMAX > 1) ? $clog2(BMAX) : 1;
   localparam int TM_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   generate
      if (OP_W > BUS_W) begin : g_op_w_check
         $error("bf_bus_seq: OP_W must not exceed BUS_W");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_OPC  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   state_t            state_r, state_nx;
   logic [BC_W-1:0]   beat_r, beat_nx;
   logic [TM_W-1:0]   timer_r, timer_nx;
   logic [OP_W-1:0]   op_r, op_nx;
   logic              write_r, write_nx;
   logic [AE_W-1:0]   addr_r, addr_nx;
   logic [DE_W-1:0]   wdata_r, wdata_nx;
   logic [DE_W-1:0]   rdata_r, rdata_nx, rdata_cap_s;
   logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_nx;
   logic              rsp_valid_r, rsp_valid_nx;
   logic              error_r, error_nx;
   logic [BUS_W-1:0]  bus_out_r, bus_out_nx;

   function automatic logic [BUS_W-1:0] opc_beat(input logic [OP_W-1:0] op, input logic wr);
      logic [BUS_W-1:0] b;
      b            = '0;
      b[OP_W-1:0]  = op;
      b[BUS_W-1]   = (BUS_W > OP_W) ? wr : b[BUS_W-1];
      return b;
   endfunction

   function automatic logic [BUS_W-1:0] addr_slice(input logic [AE_W-1:0] v, input logic [BC_W-1:0] k);
      return v[(NA - 1 - int'(k)) * BUS_W +: BUS_W];
   endfunction

   function automatic logic [BUS_W-1:0] data_slice(input logic [DE_W-1:0] v, input logic [BC_W-1:0] k);
      return v[(ND - 1 - int'(k)) * BUS_W +: BUS_W];
   endfunction

   // Read data with the current pad beat dropped into its MSB-first slot.
   always_comb begin
      rdata_cap_s = rdata_r;
      rdata_cap_s[(ND - 1 - int'(beat_r)) * BUS_W +: BUS_W] = io.bus_in;
   end

   // Next-state logic for the beat sequencer.
   always_comb begin
      state_nx     = state_r;
      beat_nx      = beat_r;
      timer_nx     = timer_r;
      op_nx        = op_r;
      write_nx     = write_r;
      addr_nx      = addr_r;
      wdata_nx     = wdata_r;
      rdata_nx     = rdata_r;
      rsp_rdata_nx = rsp_rdata_r;
      rsp_valid_nx = 1'b0;
      error_nx     = error_r;
      case (state_r)
         ST_IDLE: begin
            if (io.req_valid && (io.req_op != '0)) begin
               op_nx    = io.req_op;
               write_nx = io.req_write;
               addr_nx  = AE_W'(io.req_addr);
               wdata_nx = DE_W'(io.req_wdata);
               rdata_nx = '0;
               state_nx = ST_OPC;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_OPC: begin
            state_nx = ST_ADDR;
            beat_nx  = '0;
         end
         ST_ADDR: begin
            if (beat_r == BC_W'(NA - 1)) begin
               state_nx = ST_DATA;
               beat_nx  = '0;
               timer_nx = '0;
            end else begin
               beat_nx = beat_r + 1'b1;
            end
         end
         ST_DATA: begin
            // An ack on the cycle the timer would expire still completes the beat.
            if (io.bus_ack) begin
               timer_nx = '0;
               rdata_nx = write_r ? rdata_r : rdata_cap_s;
               if (beat_r == BC_W'(ND - 1)) begin
                  state_nx     = ST_IDLE;
                  beat_nx      = '0;
                  rsp_valid_nx = 1'b1;
                  rsp_rdata_nx = write_r ? rsp_rdata_r : DATA_W'(rdata_cap_s);
               end else begin
                  beat_nx = beat_r + 1'b1;
               end
            end else if ((TIMEOUT != 0) && (timer_r == TM_W'(TIMEOUT - 1))) begin
               state_nx = ST_ERR;
               error_nx = 1'b1;
            end else begin
               timer_nx = timer_r + 1'b1;
            end
         end
         ST_ERR: begin
            state_nx = ST_ERR;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Pad beat for the state being entered, so bus_out is registered with bus_phase.
   always_comb begin
      bus_out_nx = '0;
      case (state_nx)
         ST_OPC:  bus_out_nx = opc_beat(op_nx, write_nx);
         ST_ADDR: bus_out_nx = addr_slice(addr_nx, beat_nx);
         ST_DATA: bus_out_nx = write_nx ? data_slice(wdata_nx, beat_nx) : '0;
         default: bus_out_nx = '0;
      endcase
   end

   // State and datapath registers; enable low freezes everything.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         beat_r      <= '0;
         timer_r     <= '0;
         op_r        <= '0;
         write_r     <= 1'b0;
         addr_r      <= '0;
         wdata_r     <= '0;
         rdata_r     <= '0;
         rsp_rdata_r <= '0;
         rsp_valid_r <= 1'b0;
         error_r     <= 1'b0;
         bus_out_r   <= '0;
      end else if (enable) begin
         state_r     <= state_nx;
         beat_r      <= beat_nx;
         timer_r     <= timer_nx;
         op_r        <= op_nx;
         write_r     <= write_nx;
         addr_r      <= addr_nx;
         wdata_r     <= wdata_nx;
         rdata_r     <= rdata_nx;
         rsp_rdata_r <= rsp_rdata_nx;
         rsp_valid_r <= rsp_valid_nx;
         error_r     <= error_nx;
         bus_out_r   <= bus_out_nx;
      end
   end

   assign io.req_ready = enable && (state_r == ST_IDLE);
   assign io.rsp_valid = enable && rsp_valid_r;
   assign io.rsp_rdata = rsp_rdata_r;
   assign io.bus_out   = bus_out_r;
   assign io.bus_phase = state_r;
   assign io.error     = error_r;
endmodule
